plb_adc_capture: RTL and testbench

ADC capture engine for the PLB AD/DA peripheral set; the receive-side counterpart of the DAC output path. Generates the sample clock and power-down for an external 10-bit parallel pipelined ADC, discards the converter's pipeline latency after enable, and buffers samples in a FIFO. The MicroBlaze drains samples through a single-word read strobe from the IP interface register decode.

---
 rtl/plb_adc_capture_pkg.sv | 51 +++++
 rtl/plb_adc_capture_fifo.sv | 97 +++++++++
 rtl/plb_adc_capture.sv | 273 +++++++++++++++++++++++++++
 tb/tb_plb_adc_capture.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/plb_adc_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plb_adc_capture_pkg
// Description : Shared definitions for the PLB ADC capture engine: FSM state
//               encoding, read-word field positions, the empty-read word,
//               FIFO entry widths for both builds and a read-word packer.
// Revision    : 1.0  initial release
// ============================================================================
package plb_adc_capture_pkg;

  // Capture FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Rd_Data field positions
  localparam int RD_SAMPLE_MSB = 9;
  localparam int RD_SAMPLE_LSB = 0;
  localparam int RD_OTR_BIT    = 10;
  localparam int RD_TS_LSB     = 12;
  localparam int RD_TS_MSB     = 27;
  localparam int RD_EMPTY_BIT  = 31;

  // Word returned when a read finds the FIFO empty
  localparam logic [31:0] RD_EMPTY_WORD = 32'h8000_0000;

  // FIFO entry layout: {ts[15:0], otr, sample[9:0]} (ts only in the
  // timestamp build)
  localparam int SAMPLE_W       = 10;
  localparam int TS_W           = 16;
  localparam int ENTRY_W_BASE   = SAMPLE_W + 1;
  localparam int ENTRY_W_TSTAMP = SAMPLE_W + 1 + TS_W;

  // Assemble a read word from its fields; all unused bits are zero.
  function automatic logic [31:0] pack_word(
    input logic [SAMPLE_W-1:0] sample,
    input logic                otr,
    input logic [TS_W-1:0]     ts
  );
    logic [31:0] w;
    w = '0;
    w[RD_SAMPLE_MSB:RD_SAMPLE_LSB] = sample;
    w[RD_OTR_BIT]                  = otr;
    w[RD_TS_MSB:RD_TS_LSB]         = ts;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/plb_adc_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : plb_adc_capture_fifo
// Description : Synchronous single-clock FIFO with occupancy count, full and
//               empty flags and a synchronous flush. Head data is presented
//               combinationally (first-word fall-through).
// Revision    : 1.0  initial release
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset
//   flush    in   drop all contents (beats coincident write/read)
//   wr_en    in   write request
//   wr_data  in   WIDTH  write data
//   rd_en    in   pop request (ignored when empty)
//   rd_data  out  WIDTH  head entry
//   count    out  log2(DEPTH)+1  entries held
//   full     out  count == DEPTH
//   empty    out  count == 0
// ============================================================================
module plb_adc_capture_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic do_wr;
  logic do_rd;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A write into a full FIFO is accepted only when a pop frees the slot in
  // the same cycle.
  assign do_rd = rd_en && !flush && !empty;
  assign do_wr = wr_en && !flush && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array: contents are only meaningful behind the pointers, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/plb_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : plb_adc_capture
// Description : ADC capture engine. Generates the sample clock and power-down
//               for a 10-bit parallel pipelined ADC, discards ADC_LAT
//               conversions after enable, and buffers samples in a FIFO that
//               the processor drains one word per Rd_Req pulse.
// Revision    : 1.0  initial release
//
// Build option:
//   PLB_ADC_CAPTURE_TSTAMP_EN  store a 16-bit RUN tick counter with every
//                              sample, returned in Rd_Data[27:12].
//
// Ports:
//   Bus2IP_Clk    in   system clock
//   Bus2IP_Reset  in   asynchronous active-high reset
//   Ctrl_En       in   capture enable (level)
//   Ctrl_Clr      in   pulse: flush FIFO, clear Overflow
//   Rd_Req        in   pulse: pop FIFO head
//   Rd_Data       out  32  {empty, 0.., ts, 0, otr, sample[9:0]}
//   Rd_Valid      out  pulse qualifying Rd_Data
//   Fifo_Count    out  log2(DEPTH)+1  samples held
//   Overflow      out  sticky sample-dropped flag
//   A_Data_pin    in   [0:9] ADC data, index 0 = MSB
//   A_OTR_pin     in   ADC out-of-range
//   A_Clk_pin     out  ADC sample clock
//   A_PWRDN_pin   out  ADC power-down, active-high
// ============================================================================
module plb_adc_capture #(
  parameter int CLK_DIV = 4,
  parameter int ADC_LAT = 6,
  parameter int DEPTH   = 16
) (
  input  logic                   Bus2IP_Clk,
  input  logic                   Bus2IP_Reset,
  input  logic                   Ctrl_En,
  input  logic                   Ctrl_Clr,
  input  logic                   Rd_Req,
  output logic [31:0]            Rd_Data,
  output logic                   Rd_Valid,
  output logic [$clog2(DEPTH):0] Fifo_Count,
  output logic                   Overflow,
  input  logic [0:9]             A_Data_pin,
  input  logic                   A_OTR_pin,
  output logic                   A_Clk_pin,
  output logic                   A_PWRDN_pin
);

  import plb_adc_capture_pkg::*;

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [3:0]       LAT_END  = 4'(ADC_LAT);

`ifdef PLB_ADC_CAPTURE_TSTAMP_EN
  localparam int ENTRY_W = ENTRY_W_TSTAMP;
`else
  localparam int ENTRY_W = ENTRY_W_BASE;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e                state_q,   state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [3:0]            lat_cnt_q, lat_cnt_d;
  logic                  a_clk_q,   a_clk_d;
  logic                  a_pwrdn_q, a_pwrdn_d;
  logic [SAMPLE_W-1:0]   in_data_q, in_data_d;
  logic                  in_otr_q,  in_otr_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [31:0]           rd_data_q,  rd_data_d;
  logic                  overflow_q, overflow_d;

  logic                  tick;
  logic [3:0]            lat_inc;

  logic                  fifo_wr;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  rd_pop;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    head_entry;
  logic [TS_W-1:0]       head_ts;
  logic [CNT_W-1:0]      fifo_count;

  // The tick is the last divider phase, just before A_Clk_pin rises.
  assign tick    = (state_q != ST_IDLE) && (div_cnt_q == DIV_LAST);
  assign lat_inc = lat_cnt_q + 4'd1;

  // --------------------------------------------------------------------------
  // FSM, divider and input register
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    lat_cnt_d = lat_cnt_q;
    in_data_d = in_data_q;
    in_otr_d  = in_otr_q;

    if (!Ctrl_En) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          lat_cnt_d = '0;
          state_d   = (ADC_LAT == 0) ? ST_RUN : ST_FLUSH;
        end
        ST_FLUSH: begin
          if (tick) begin
            lat_cnt_d = lat_inc;
            if (lat_inc == LAT_END) state_d = ST_RUN;
          end
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end

    // Divider is parked at 0 in IDLE so the first sample phase after
    // enable is a full CLK_DIV period long.
    if (state_q == ST_IDLE || state_d == ST_IDLE) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end

    if (tick) begin
      in_data_d = A_Data_pin;
      in_otr_d  = A_OTR_pin;
    end

    // Only RUN ticks produce a FIFO write, one cycle later.
    wr_pend_d = tick && (state_q == ST_RUN) && Ctrl_En;

    // Outputs registered from the next-state values so the pins track the
    // divider phase without a cycle of skew.
    a_clk_d   = (state_d != ST_IDLE) && (div_cnt_d < DIV_HALF);
    a_pwrdn_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      lat_cnt_q <= '0;
      a_clk_q   <= 1'b0;
      a_pwrdn_q <= 1'b1;
      in_data_q <= '0;
      in_otr_q  <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      a_clk_q   <= a_clk_d;
      a_pwrdn_q <= a_pwrdn_d;
      in_data_q <= in_data_d;
      in_otr_q  <= in_otr_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional RUN-tick timestamp
  // --------------------------------------------------------------------------
`ifdef PLB_ADC_CAPTURE_TSTAMP_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0] in_ts_q,  in_ts_d;

  // Counts every RUN tick, including ones whose sample is later dropped,
  // so gaps in the timestamp sequence expose overflow losses.
  always_comb begin
    ts_cnt_d = ts_cnt_q;
    in_ts_d  = in_ts_q;
    if (state_q != ST_RUN && state_d == ST_RUN) begin
      ts_cnt_d = '0;
    end else if (tick && state_q == ST_RUN) begin
      ts_cnt_d = ts_cnt_q + TS_W'(1);
    end
    if (tick) in_ts_d = ts_cnt_q;
  end

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      ts_cnt_q <= '0;
      in_ts_q  <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      in_ts_q  <= in_ts_d;
    end
  end

  assign wr_entry = {in_ts_q, in_otr_q, in_data_q};
  assign head_ts  = head_entry[ENTRY_W-1:SAMPLE_W+1];
`else
  assign wr_entry = {in_otr_q, in_data_q};
  assign head_ts  = '0;
`endif

  // --------------------------------------------------------------------------
  // Sample FIFO
  // --------------------------------------------------------------------------
  // A pending write is dropped if capture is disabled before it lands.
  assign fifo_wr = wr_pend_q && Ctrl_En;

  plb_adc_capture_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (Bus2IP_Clk),
    .rst     (Bus2IP_Reset),
    .flush   (Ctrl_Clr),
    .wr_en   (fifo_wr),
    .wr_data (wr_entry),
    .rd_en   (Rd_Req),
    .rd_data (head_entry),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Mirrors the FIFO's own pop qualification.
  assign rd_pop = Rd_Req && !Ctrl_Clr && !fifo_empty;

  // --------------------------------------------------------------------------
  // Read port and overflow flag
  // --------------------------------------------------------------------------
  always_comb begin
    rd_valid_d = Rd_Req;
    rd_data_d  = rd_data_q;
    overflow_d = overflow_q;

    if (Rd_Req) begin
      rd_data_d = rd_pop ? pack_word(head_entry[SAMPLE_W-1:0],
                                     head_entry[SAMPLE_W], head_ts)
                         : RD_EMPTY_WORD;
    end

    // A write into a full FIFO loses its sample unless a pop coincides.
    if (Ctrl_Clr) begin
      overflow_d = 1'b0;
    end else if (fifo_wr && fifo_full && !rd_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge Bus2IP_Clk or posedge Bus2IP_Reset) begin
    if (Bus2IP_Reset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign Rd_Data     = rd_data_q;
  assign Rd_Valid    = rd_valid_q;
  assign Fifo_Count  = fifo_count;
  assign Overflow    = overflow_q;
  assign A_Clk_pin   = a_clk_q;
  assign A_PWRDN_pin = a_pwrdn_q;

endmodule
`default_nettype wire

// File: tb/tb_plb_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_plb_adc_capture
// Description : Self-checking bench for plb_adc_capture. Stimulus follows the
//               sample-tick schedule implied by CLK_DIV and ADC_LAT; expected
//               read words are queued when the ADC value is driven and popped
//               when the DUT returns a read.
// Revision    : 1.0  initial release
// ============================================================================
module tb_plb_adc_capture;

  localparam int CLK_DIV = 4;
  localparam int ADC_LAT = 6;
  localparam int DEPTH   = 16;
`ifdef PLB_ADC_CAPTURE_TSTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic        Bus2IP_Clk   = 1'b0;
  logic        Bus2IP_Reset = 1'b1;
  logic        Ctrl_En      = 1'b0;
  logic        Ctrl_Clr     = 1'b0;
  logic        Rd_Req       = 1'b0;
  logic [31:0] Rd_Data;
  logic        Rd_Valid;
  logic [4:0]  Fifo_Count;
  logic        Overflow;
  logic [0:9]  A_Data_pin   = '0;
  logic        A_OTR_pin    = 1'b0;
  logic        A_Clk_pin;
  logic        A_PWRDN_pin;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          cap_on   = 1'b0;
  bit          otr_mode = 1'b0;
  logic [31:0] sb[$];

  plb_adc_capture #(
    .CLK_DIV (CLK_DIV),
    .ADC_LAT (ADC_LAT),
    .DEPTH   (DEPTH)
  ) dut (
    .Bus2IP_Clk   (Bus2IP_Clk),
    .Bus2IP_Reset (Bus2IP_Reset),
    .Ctrl_En      (Ctrl_En),
    .Ctrl_Clr     (Ctrl_Clr),
    .Rd_Req       (Rd_Req),
    .Rd_Data      (Rd_Data),
    .Rd_Valid     (Rd_Valid),
    .Fifo_Count   (Fifo_Count),
    .Overflow     (Overflow),
    .A_Data_pin   (A_Data_pin),
    .A_OTR_pin    (A_OTR_pin),
    .A_Clk_pin    (A_Clk_pin),
    .A_PWRDN_pin  (A_PWRDN_pin)
  );

  always #5 Bus2IP_Clk = ~Bus2IP_Clk;

  function automatic logic [31:0] exp_word(input logic [9:0] d, input logic otr, input int ts);
    logic [31:0] w;
    w        = 32'h0;
    w[9:0]   = d;
    w[10]    = otr;
    if (TS_ON) w[27:12] = 16'(ts);
    return w;
  endfunction

  // One clock: advance, then drive the ADC value that tick k will sample.
  // Cycle 0 is the edge after which Ctrl_En was raised; tick k samples at
  // edge CLK_DIV*k+1, and ticks beyond ADC_LAT are RUN ticks.
  task automatic step();
    int k;
    logic [9:0] d;
    @(posedge Bus2IP_Clk);
    #1;
    cyc++;
    if (cap_on && (cyc % CLK_DIV) == 0) begin
      k = cyc / CLK_DIV;
      d = otr_mode ? 10'h3FF : 10'(k - 1);
      A_Data_pin = d;
      A_OTR_pin  = otr_mode;
      if (k > ADC_LAT && sb.size() < DEPTH)
        sb.push_back(exp_word(d, otr_mode, k - (ADC_LAT + 1)));
    end
  endtask

  task automatic start_capture(input bit otr);
    otr_mode = otr;
    Ctrl_En  = 1'b1;
    cap_on   = 1'b1;
    cyc      = 0;
  endtask

  task automatic stop_capture();
    Ctrl_En  = 1'b0;
    cap_on   = 1'b0;
    otr_mode = 1'b0;
  endtask

  task automatic test_reset();
    Bus2IP_Reset = 1'b1;
    repeat (3) step();
    n_checks++; if (A_Clk_pin !== 1'b0) begin n_fail++; $display("FAIL reset_aclk: got %b want 0", A_Clk_pin); end
    n_checks++; if (A_PWRDN_pin !== 1'b1) begin n_fail++; $display("FAIL reset_pwrdn: got %b want 1", A_PWRDN_pin); end
    n_checks++; if (Rd_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", Rd_Valid); end
    n_checks++; if (Rd_Data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00000000", Rd_Data); end
    n_checks++; if (Fifo_Count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", Fifo_Count); end
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", Overflow); end
    Bus2IP_Reset = 1'b0;
    step();
  endtask

  task automatic test_first_sample();
    start_capture(1'b0);
    for (int i = 0; i < 200 && Fifo_Count == 5'd0; i++) step();
    n_checks++; if (cyc != 30) begin n_fail++; $display("FAIL first_latency: got %0d cycles want 30", cyc); end
    n_checks++; if (Fifo_Count !== 5'd1) begin n_fail++; $display("FAIL first_count: got %0d want 1", Fifo_Count); end
    n_checks++; if (A_PWRDN_pin !== 1'b0) begin n_fail++; $display("FAIL run_pwrdn: got %b want 0", A_PWRDN_pin); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 200 && Fifo_Count != 5'd16; i++) step();
    // two more ticks land on the full FIFO
    while (cyc < 99) step();
    n_checks++; if (Fifo_Count !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d want 16", Fifo_Count); end
    n_checks++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b want 1", Overflow); end
  endtask

  task automatic test_full_rw();
    logic [31:0] exp;
    exp = sb.pop_front();           // the pop frees a slot for tick 25
    step();                         // cycle 100: tick 25 value driven
    step();                         // cycle 101
    Rd_Req = 1'b1;
    step();                         // cycle 102: read and write coincide
    Rd_Req = 1'b0;
    stop_capture();
    n_checks++; if (Rd_Valid !== 1'b1) begin n_fail++; $display("FAIL full_rw_valid: got %b want 1", Rd_Valid); end
    n_checks++; if (Rd_Data !== exp) begin n_fail++; $display("FAIL full_rw_data: got %h want %h", Rd_Data, exp); end
    n_checks++; if (Rd_Data[9:0] !== 10'h006) begin n_fail++; $display("FAIL first_word: got %h want 006", Rd_Data[9:0]); end
    n_checks++; if (Fifo_Count !== 5'd16) begin n_fail++; $display("FAIL full_rw_count: got %0d want 16", Fifo_Count); end
  endtask

  task automatic test_drain();
    logic [31:0] exp;
    for (int i = 0; i < DEPTH; i++) begin
      Rd_Req = 1'b1;
      step();
      Rd_Req = 1'b0;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++; $display("FAIL drain_%0d: got %h want no entry left in model", i, Rd_Data);
      end else begin
        exp = sb.pop_front();
        if (Rd_Valid !== 1'b1 || Rd_Data !== exp) begin
          n_fail++; $display("FAIL drain_%0d: got valid=%b data=%h want valid=1 data=%h", i, Rd_Valid, Rd_Data, exp);
        end
      end
      if (i == 0) begin
        n_checks++; if (Rd_Data[9:0] !== 10'h007) begin n_fail++; $display("FAIL second_oldest: got %h want 007", Rd_Data[9:0]); end
      end
    end
    n_checks++; if (Fifo_Count !== 5'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", Fifo_Count); end
    n_checks++; if (Overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky: got %b want 1", Overflow); end
  endtask

  task automatic test_empty_read();
    Rd_Req = 1'b1;
    step();
    Rd_Req = 1'b0;
    n_checks++; if (Rd_Valid !== 1'b1) begin n_fail++; $display("FAIL empty_valid: got %b want 1", Rd_Valid); end
    n_checks++; if (Rd_Data !== 32'h8000_0000) begin n_fail++; $display("FAIL empty_word: got %h want 80000000", Rd_Data); end
    step();
    n_checks++; if (Rd_Valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse: got %b want 0", Rd_Valid); end
    n_checks++; if (Fifo_Count !== 5'd0) begin n_fail++; $display("FAIL empty_count: got %0d want 0", Fifo_Count); end
  endtask

  task automatic test_stop_clear();
    start_capture(1'b0);
    for (int i = 0; i < 200 && Fifo_Count < 5'd2; i++) step();
    stop_capture();
    step();
    n_checks++; if (A_PWRDN_pin !== 1'b1) begin n_fail++; $display("FAIL stop_pwrdn: got %b want 1", A_PWRDN_pin); end
    n_checks++; if (A_Clk_pin !== 1'b0) begin n_fail++; $display("FAIL stop_aclk: got %b want 0", A_Clk_pin); end
    repeat (8) step();
    n_checks++; if (Fifo_Count !== 5'd2) begin n_fail++; $display("FAIL stop_kept: got %0d want 2", Fifo_Count); end
    Ctrl_Clr = 1'b1;
    step();
    Ctrl_Clr = 1'b0;
    n_checks++; if (Fifo_Count !== 5'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", Fifo_Count); end
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow: got %b want 0", Overflow); end
    sb.delete();
  endtask

  task automatic test_otr();
    start_capture(1'b1);
    for (int i = 0; i < 200 && Fifo_Count == 5'd0; i++) step();
    stop_capture();
    Rd_Req = 1'b1;
    step();
    Rd_Req = 1'b0;
    n_checks++; if (Rd_Valid !== 1'b1 || Rd_Data !== 32'h0000_07FF) begin n_fail++; $display("FAIL otr_word: got valid=%b data=%h want valid=1 data=000007ff", Rd_Valid, Rd_Data); end
    sb.delete();
  endtask

  task automatic test_tstamp();
    logic [31:0] exp;
    start_capture(1'b0);
    for (int i = 0; i < 200 && Fifo_Count < 5'd3; i++) step();
    stop_capture();
    for (int i = 0; i < 3; i++) begin
      Rd_Req = 1'b1;
      step();
      Rd_Req = 1'b0;
      n_checks++; if (Rd_Data[27:12] !== 16'(i)) begin n_fail++; $display("FAIL tstamp_%0d: got %0d want %0d", i, Rd_Data[27:12], i); end
      exp = (sb.size() != 0) ? sb.pop_front() : 32'hFFFF_FFFF;
      n_checks++; if (Rd_Data !== exp) begin n_fail++; $display("FAIL tstamp_word_%0d: got %h want %h", i, Rd_Data, exp); end
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_run();
    start_capture(1'b0);
    for (int i = 0; i < 200 && Fifo_Count < 5'd2; i++) step();
    Rd_Req = 1'b1;
    step();
    Rd_Req = 1'b0;
    #2;
    Bus2IP_Reset = 1'b1;
    #1;
    n_checks++; if (A_Clk_pin !== 1'b0) begin n_fail++; $display("FAIL midrst_aclk: got %b want 0", A_Clk_pin); end
    n_checks++; if (A_PWRDN_pin !== 1'b1) begin n_fail++; $display("FAIL midrst_pwrdn: got %b want 1", A_PWRDN_pin); end
    n_checks++; if (Rd_Valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", Rd_Valid); end
    n_checks++; if (Rd_Data !== 32'h0) begin n_fail++; $display("FAIL midrst_data: got %h want 00000000", Rd_Data); end
    n_checks++; if (Fifo_Count !== 5'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", Fifo_Count); end
    n_checks++; if (Overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow: got %b want 0", Overflow); end
    stop_capture();
    sb.delete();
    step();
    step();
    Bus2IP_Reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_overflow();
    test_full_rw();
    test_drain();
    test_empty_read();
    test_stop_clear();
    test_otr();
    if (TS_ON) test_tstamp();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
